mc_seq_ctrl: RTL and testbench

Parametrised motion-compensation / reconstruction sequencer for the rec_mc path. It runs per-CU luma TQ, then chroma interpolation and chroma TQ for each enabled chroma plane. Luma TQ and any chroma plane can be skipped per start. It holds a one-deep pending start, supports synchronous abort, and drives registered one-cycle start pulses to the chroma interpolator and the TQ engine.

---
 rtl/mc_seq_if.sv | 36 +++
 rtl/mc_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mc_seq_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_if.sv
// mc_seq_if: handshake bundle between the rec_mc sequencer and its environment.
// Ports (slave = sequencer view):
//   in : mc_start_i, mc_luma_en_i, mc_chroma_en_i[CH_NUM], mc_abort_i, chroma_done_i, tq_done_i
//   out: mc_busy_o, mc_done_o, mc_overrun_o, mvd_access_o, chroma_start_o,
//        chroma_sel_o[CH_W], tq_start_o, tq_sel_o[CH_W+1]
interface mc_seq_if #(
    parameter int CH_NUM = 2,
    parameter int CH_W   = 1
);
    logic              mc_start_i;
    logic              mc_luma_en_i;
    logic [CH_NUM-1:0] mc_chroma_en_i;
    logic              mc_abort_i;
    logic              mc_busy_o;
    logic              mc_done_o;
    logic              mc_overrun_o;
    logic              mvd_access_o;
    logic              chroma_start_o;
    logic [CH_W-1:0]   chroma_sel_o;
    logic              chroma_done_i;
    logic              tq_start_o;
    logic [CH_W:0]     tq_sel_o;
    logic              tq_done_i;

    modport slave (
        input  mc_start_i, mc_luma_en_i, mc_chroma_en_i, mc_abort_i, chroma_done_i, tq_done_i,
        output mc_busy_o, mc_done_o, mc_overrun_o, mvd_access_o, chroma_start_o, chroma_sel_o,
               tq_start_o, tq_sel_o
    );

    modport master (
        output mc_start_i, mc_luma_en_i, mc_chroma_en_i, mc_abort_i, chroma_done_i, tq_done_i,
        input  mc_busy_o, mc_done_o, mc_overrun_o, mvd_access_o, chroma_start_o, chroma_sel_o,
               tq_start_o, tq_sel_o
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: per-CU luma TQ then chroma interpolation + TQ per enabled plane.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  mc_seq_if.slave: start/enables/abort in, busy/done/overrun out,
//        chroma interpolator and TQ engine start pulses, selects and done inputs
module mc_seq_ctrl #(
    parameter int CH_NUM = 2,
    parameter int CH_W   = 1
) (
    input logic     clk,
    input logic     rst,
    mc_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, TQ_LUMA, MC_CH, TQ_CH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_NUM-1:0] rem_q, rem_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              pend_q, pend_d;
    logic              pend_luma_q, pend_luma_d;
    logic [CH_NUM-1:0] pend_chroma_q, pend_chroma_d;
    logic              first_q;
    logic              tq_start_q, chroma_start_q, overrun_q, overrun_d;
    logic              accept, acc_luma, tq_ok, ch_ok, nxt_any;
    logic [CH_NUM-1:0] acc_mask, scan;
    logic [CH_W-1:0]   nxt_ch;

    // A pending start is always served before a fresh one; abort blocks both.
    assign accept   = state_q == IDLE && !bus.mc_abort_i && (pend_q || bus.mc_start_i);
    assign acc_luma = pend_q ? pend_luma_q : bus.mc_luma_en_i;
    assign acc_mask = pend_q ? pend_chroma_q : bus.mc_chroma_en_i;
    // Done inputs are not trusted in the cycle their start pulse is issued.
    assign tq_ok    = bus.tq_done_i && !first_q;
    assign ch_ok    = bus.chroma_done_i && !first_q;

    // Single priority encoder feeds every next-plane decision.
    assign scan = state_q == IDLE  ? acc_mask :
                  state_q == TQ_CH ? rem_q & ~(CH_NUM'(1) << ch_q) : rem_q;

    always_comb begin
        nxt_any = |scan;
        nxt_ch  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (scan[i]) nxt_ch = CH_W'(i);
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        ch_d          = ch_q;
        pend_d        = pend_q;
        pend_luma_d   = pend_luma_q;
        pend_chroma_d = pend_chroma_q;
        overrun_d     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                rem_d = acc_mask;
                if (acc_luma) state_d = TQ_LUMA;
                else if (nxt_any) begin
                    state_d = MC_CH;
                    ch_d    = nxt_ch;
                end else state_d = DONE;
            end
            TQ_LUMA: if (tq_ok) begin
                state_d = nxt_any ? MC_CH : DONE;
                ch_d    = nxt_any ? nxt_ch : ch_q;
            end
            MC_CH: if (ch_ok) state_d = TQ_CH;
            TQ_CH: if (tq_ok) begin
                rem_d   = scan;
                state_d = nxt_any ? MC_CH : DONE;
                ch_d    = nxt_any ? nxt_ch : ch_q;
            end
            default: state_d = IDLE;
        endcase
        // In IDLE a start is latched only when the pending slot is being served
        // in the same cycle; while busy it is latched only into an empty slot.
        if (bus.mc_abort_i) begin
            pend_d = 1'b0;
            rem_d  = '0;
            if (state_q != IDLE) state_d = IDLE;
        end else if (bus.mc_start_i && (pend_q ? state_q == IDLE : state_q != IDLE)) begin
            pend_d        = 1'b1;
            pend_luma_d   = bus.mc_luma_en_i;
            pend_chroma_d = bus.mc_chroma_en_i;
        end else if (bus.mc_start_i && pend_q) overrun_d = 1'b1;
        else if (state_q == IDLE) pend_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            ch_q           <= '0;
            pend_q         <= 1'b0;
            pend_luma_q    <= 1'b0;
            pend_chroma_q  <= '0;
            first_q        <= 1'b0;
            tq_start_q     <= 1'b0;
            chroma_start_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            ch_q           <= ch_d;
            pend_q         <= pend_d;
            pend_luma_q    <= pend_luma_d;
            pend_chroma_q  <= pend_chroma_d;
            first_q        <= state_d != state_q && (state_d == TQ_LUMA || state_d == MC_CH || state_d == TQ_CH);
            tq_start_q     <= state_d != state_q && (state_d == TQ_LUMA || state_d == TQ_CH);
            chroma_start_q <= state_d != state_q && state_d == MC_CH;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.mc_busy_o      = state_q != IDLE;
    assign bus.mc_done_o      = state_q == DONE;
    assign bus.mc_overrun_o   = overrun_q;
    assign bus.mvd_access_o   = state_q == TQ_LUMA;
    assign bus.chroma_start_o = chroma_start_q;
    assign bus.chroma_sel_o   = ch_q;
    assign bus.tq_start_o     = tq_start_q;
    assign bus.tq_sel_o       = state_q == TQ_CH ? {1'b1, ch_q} : '0;
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: directed checks of mc_seq_ctrl with two and three chroma planes.
module tb_mc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    mc_seq_if #(.CH_NUM(2), .CH_W(1)) m2 ();
    mc_seq_if #(.CH_NUM(3), .CH_W(2)) m3 ();

    mc_seq_ctrl #(.CH_NUM(2), .CH_W(1)) dut2 (.clk(clk), .rst(rst), .bus(m2));
    mc_seq_ctrl #(.CH_NUM(3), .CH_W(2)) dut3 (.clk(clk), .rst(rst), .bus(m3));

    always #5 clk = ~clk;

    always @(negedge clk) if (m2.mc_done_o) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start2(input logic luma, input logic [1:0] mask);
        m2.mc_start_i = 1'b1;
        m2.mc_luma_en_i = luma;
        m2.mc_chroma_en_i = mask;
        tick();
        m2.mc_start_i = 1'b0;
    endtask

    task automatic resp2(input bit tq, input int gap);
        repeat (gap) tick();
        if (tq) m2.tq_done_i = 1'b1; else m2.chroma_done_i = 1'b1;
        tick();
        m2.tq_done_i = 1'b0;
        m2.chroma_done_i = 1'b0;
    endtask

    task automatic resp3(input bit tq, input int gap);
        repeat (gap) tick();
        if (tq) m3.tq_done_i = 1'b1; else m3.chroma_done_i = 1'b1;
        tick();
        m3.tq_done_i = 1'b0;
        m3.chroma_done_i = 1'b0;
    endtask

    initial begin
        int d0;
        {m2.mc_start_i, m2.mc_luma_en_i, m2.mc_chroma_en_i, m2.mc_abort_i, m2.chroma_done_i, m2.tq_done_i} = '0;
        {m3.mc_start_i, m3.mc_luma_en_i, m3.mc_chroma_en_i, m3.mc_abort_i, m3.chroma_done_i, m3.tq_done_i} = '0;
        #1;
        chk("rst_busy", m2.mc_busy_o, 0);
        chk("rst_outs", {m2.mc_done_o, m2.mc_overrun_o, m2.mvd_access_o, m2.chroma_start_o, m2.tq_start_o}, 0);
        chk("rst_sels", {m2.chroma_sel_o, m2.tq_sel_o}, 0);
        tick();
        rst = 1'b0;
        tick();

        // full sequence: luma + planes 0,1, done 3 cycles after each start
        d0 = done_cnt;
        start2(1'b1, 2'b11);
        chk("full_tq0_start", m2.tq_start_o, 1);
        chk("full_tq0_sel", m2.tq_sel_o, 0);
        chk("full_mvd", m2.mvd_access_o, 1);
        tick();
        chk("full_tq0_once", m2.tq_start_o, 0);
        resp2(1'b1, 2);
        chk("full_mc0_start", m2.chroma_start_o, 1);
        chk("full_mc0_sel", m2.chroma_sel_o, 0);
        chk("full_mvd_off", m2.mvd_access_o, 0);
        resp2(1'b0, 3);
        chk("full_tq1_start", m2.tq_start_o, 1);
        chk("full_tq1_sel", m2.tq_sel_o, 2);
        resp2(1'b1, 3);
        chk("full_mc1_start", m2.chroma_start_o, 1);
        chk("full_mc1_sel", m2.chroma_sel_o, 1);
        resp2(1'b0, 3);
        chk("full_tq2_sel", m2.tq_sel_o, 3);
        chk("full_mvd_ch", m2.mvd_access_o, 0);
        resp2(1'b1, 3);
        chk("full_done", m2.mc_done_o, 1);
        tick();
        chk("full_idle", m2.mc_busy_o, 0);
        chk("full_done_cnt", done_cnt - d0, 1);

        // skip luma, plane 1 only
        start2(1'b0, 2'b10);
        chk("skip_mc_start", m2.chroma_start_o, 1);
        chk("skip_mc_sel", m2.chroma_sel_o, 1);
        chk("skip_no_tq", m2.tq_start_o, 0);
        resp2(1'b0, 1);
        chk("skip_tq_sel", m2.tq_sel_o, 3);
        chk("skip_tq_start", m2.tq_start_o, 1);
        resp2(1'b1, 1);
        chk("skip_done", m2.mc_done_o, 1);
        tick();

        // all disabled
        start2(1'b0, 2'b00);
        chk("none_done", m2.mc_done_o, 1);
        chk("none_pulses", {m2.tq_start_o, m2.chroma_start_o}, 0);
        tick();
        chk("none_idle", m2.mc_busy_o, 0);

        // pending start then overrun
        start2(1'b1, 2'b00);
        start2(1'b0, 2'b10);
        chk("pend_no_ovr", m2.mc_overrun_o, 0);
        start2(1'b1, 2'b01);
        chk("pend_ovr", m2.mc_overrun_o, 1);
        tick();
        chk("pend_ovr_once", m2.mc_overrun_o, 0);
        resp2(1'b1, 0);
        chk("pend_a_done", m2.mc_done_o, 1);
        tick();
        chk("pend_gap_idle", m2.mc_busy_o, 0);
        tick();
        chk("pend_b_mc", m2.chroma_start_o, 1);
        chk("pend_b_sel", m2.chroma_sel_o, 1);
        chk("pend_b_no_luma", m2.mvd_access_o, 0);
        resp2(1'b0, 1);
        resp2(1'b1, 1);
        chk("pend_b_done", m2.mc_done_o, 1);
        tick();
        tick();
        chk("pend_c_dropped", m2.mc_busy_o, 0);

        // abort in MC_CH with a pending start
        d0 = done_cnt;
        start2(1'b0, 2'b01);
        start2(1'b1, 2'b11);
        m2.mc_abort_i = 1'b1;
        tick();
        m2.mc_abort_i = 1'b0;
        chk("abort_idle", m2.mc_busy_o, 0);
        chk("abort_no_done", m2.mc_done_o, 0);
        m2.chroma_done_i = 1'b1;
        tick();
        m2.chroma_done_i = 1'b0;
        chk("abort_late_done", {m2.mc_busy_o, m2.tq_start_o, m2.chroma_start_o}, 0);
        tick();
        chk("abort_pend_gone", m2.mc_busy_o, 0);
        chk("abort_done_cnt", done_cnt - d0, 0);

        // early and stray done inputs
        start2(1'b1, 2'b01);
        m2.tq_done_i = 1'b1;
        tick();
        m2.tq_done_i = 1'b0;
        chk("early_tq_held", m2.mvd_access_o, 1);
        chk("early_tq_no_mc", m2.chroma_start_o, 0);
        m2.chroma_done_i = 1'b1;
        tick();
        m2.chroma_done_i = 1'b0;
        chk("stray_ch_held", m2.mvd_access_o, 1);
        resp2(1'b1, 0);
        chk("early_then_mc", m2.chroma_start_o, 1);
        m2.mc_abort_i = 1'b1;
        tick();
        m2.mc_abort_i = 1'b0;
        chk("early_abort", m2.mc_busy_o, 0);

        // three planes, mask 101, then async reset inside TQ_CH
        m3.mc_start_i = 1'b1;
        m3.mc_luma_en_i = 1'b1;
        m3.mc_chroma_en_i = 3'b101;
        tick();
        m3.mc_start_i = 1'b0;
        chk("g3_tq0_sel", m3.tq_sel_o, 0);
        chk("g3_tq0_start", m3.tq_start_o, 1);
        resp3(1'b1, 1);
        chk("g3_mc0_sel", m3.chroma_sel_o, 0);
        resp3(1'b0, 1);
        chk("g3_tq1_sel", m3.tq_sel_o, 3'b100);
        resp3(1'b1, 1);
        chk("g3_mc2_start", m3.chroma_start_o, 1);
        chk("g3_mc2_sel", m3.chroma_sel_o, 2);
        resp3(1'b0, 1);
        chk("g3_tq2_sel", m3.tq_sel_o, 3'b110);
        #2 rst = 1'b1;
        #1;
        chk("g3_arst_busy", m3.mc_busy_o, 0);
        chk("g3_arst_outs", {m3.tq_sel_o, m3.chroma_sel_o, m3.tq_start_o, m3.chroma_start_o, m3.mc_done_o}, 0);
        tick();
        rst = 1'b0;
        m3.tq_done_i = 1'b1;
        tick();
        m3.tq_done_i = 1'b0;
        chk("g3_post_rst_done", {m3.mc_busy_o, m3.mc_done_o, m3.chroma_start_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
